board_write_arbiter: RTL and testbench

- Shares the single cell-board write port between three masters: generation engine (gen), fill traversal engine (fill: clear/random/pattern), and cursor user edit (usr).
- Grants bursts round-robin and masks masters by `mode`: gen only in run mode, fill and usr only in edit mode.
- Forwards the owner's address and data to the board and enforces a maximum burst length.
- Sits between the evolve control path and the cell board RAM.

---
 rtl/board_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_board_write_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : board_write_arbiter
// Purpose  : Shares the single cell-board write port between the generation
//            engine (gen), the fill traversal engine (fill) and the cursor
//            user edit path (usr). Bursts are granted round-robin, masters are
//            masked by mode (gen in run mode, fill/usr in edit mode), and a
//            burst is force-released after MAX_BURST beats without a last.
// Ports    : clk, rst (async, active-high)
//            mode              1 = run, 0 = edit
//            req/last/wdata_in per-master, bit0 gen, bit1 fill, bit2 usr
//            addrR_in/addrC_in 8 bits per master, master i at [8i+7:8i]
//            gnt               one-hot registered grant
//            wAddrR/wAddrC/write_en/write_data  board write port
//            busy              grant held
//            timeout           one-cycle pulse after a forced release
// Revision : 1.0 - initial release
// ============================================================================
module board_write_arbiter #(
    parameter int MAP_WIDTH  = 8,
    parameter int MAP_HEIGHT = 8,
    parameter int MAX_BURST  = MAP_WIDTH * MAP_HEIGHT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic [2:0]  req,
    input  logic [2:0]  last,
    input  logic [23:0] addrR_in,
    input  logic [23:0] addrC_in,
    input  logic [2:0]  wdata_in,
    output logic [2:0]  gnt,
    output logic [7:0]  wAddrR,
    output logic [7:0]  wAddrC,
    output logic        write_en,
    output logic        write_data,
    output logic        busy,
    output logic        timeout
);

    generate
        if (MAX_BURST < 1 || MAX_BURST > 65535 || MAP_WIDTH > 256 || MAP_HEIGHT > 256) begin : g_bad_param
            $error("board_write_arbiter: parameter out of range");
        end
    endgenerate

    localparam logic [15:0] C_LAST_BEAT = 16'(MAX_BURST - 1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_OWN = 1'b1} state_t;

    state_t      r_state;
    logic [2:0]  r_gnt;
    logic [1:0]  r_ptr;
    logic [15:0] r_beat_cnt;
    logic        r_timeout;

    logic [2:0]  w_mask;
    logic [2:0]  w_elig;
    logic [1:0]  w_own;
    logic        w_own_act;
    logic        w_at_max;
    logic        w_release;
    logic        w_force;
    logic        w_pick_valid;
    logic [1:0]  w_pick;
    int          w_idx;

    // gen only in run mode, fill/usr only in edit mode
    assign w_mask = {~mode, ~mode, mode};
    assign w_elig = req & w_mask;

    // Round-robin scan ptr, ptr+1, ptr+2 (mod 3); scanning from the far end
    // lets the nearest eligible master overwrite the choice last.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick       = 2'd0;
        w_idx        = 0;
        for (int k = 2; k >= 0; k--) begin
            w_idx = (int'(r_ptr) + k) % 3;
            if (w_elig[w_idx]) begin
                w_pick_valid = 1'b1;
                w_pick       = 2'(w_idx);
            end
        end
    end

    always_comb begin
        case (r_gnt)
            3'b010:  w_own = 2'd1;
            3'b100:  w_own = 2'd2;
            default: w_own = 2'd0;
        endcase
    end

    // A mode flip masks the owner in the same cycle, so no beat slips through.
    assign w_own_act = (r_state == S_OWN) & req[w_own] & w_mask[w_own];
    assign w_at_max  = (r_beat_cnt == C_LAST_BEAT);
    // Timeout only when the cap is hit on a beat that is not already the last
    assign w_force   = w_own_act & ~last[w_own] & w_at_max;
    assign w_release = ~req[w_own] | ~w_mask[w_own] | (w_own_act & last[w_own]) | w_force;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= 3'b000;
            r_ptr      <= 2'd0;
            r_beat_cnt <= 16'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        r_gnt      <= 3'b001 << w_pick;
                        r_beat_cnt <= 16'd0;
                        r_state    <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (w_own_act && r_beat_cnt != 16'hFFFF) begin
                        r_beat_cnt <= r_beat_cnt + 16'd1;
                    end
                    if (w_release) begin
                        r_gnt     <= 3'b000;
                        r_ptr     <= (w_own == 2'd2) ? 2'd0 : w_own + 2'd1;
                        r_state   <= S_IDLE;
                        r_timeout <= w_force;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 3'b000;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign busy       = |r_gnt;
    assign timeout    = r_timeout;
    assign write_en   = w_own_act;
    assign wAddrR     = w_own_act ? addrR_in[{w_own, 3'b000} +: 8] : 8'd0;
    assign wAddrC     = w_own_act ? addrC_in[{w_own, 3'b000} +: 8] : 8'd0;
    assign write_data = w_own_act ? wdata_in[w_own] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_board_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_write_arbiter
// Purpose  : Directed self-checking bench for board_write_arbiter. Expected
//            board writes are queued when stimulus is driven and popped when
//            the DUT raises write_en.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [2:0]  req;
    logic [2:0]  last;
    logic [23:0] addrR_in;
    logic [23:0] addrC_in;
    logic [2:0]  wdata_in;
    logic [2:0]  gnt;
    logic [7:0]  wAddrR;
    logic [7:0]  wAddrC;
    logic        write_en;
    logic        write_data;
    logic        busy;
    logic        timeout;

    int n_chk  = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int to_cnt = 0;
    int we_base;
    int to_base;
    logic [16:0] sb[$];
    logic [16:0] exp_w;

    board_write_arbiter dut (
        .clk(clk), .rst(rst), .mode(mode), .req(req), .last(last),
        .addrR_in(addrR_in), .addrC_in(addrC_in), .wdata_in(wdata_in),
        .gnt(gnt), .wAddrR(wAddrR), .wAddrC(wAddrC), .write_en(write_en),
        .write_data(write_data), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer and structural invariants, sampled on the falling edge
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
            if (write_en) begin
                we_cnt++;
                check("we_needs_gnt", {29'd0, gnt} != 0, 32'd1);
                n_chk++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_unexpected_write observed=%0h expected=none", {wAddrR, wAddrC, write_data});
                end
                if (sb.size() != 0) begin
                    exp_w = sb.pop_front();
                    check("sb_write", {15'd0, wAddrR, wAddrC, write_data}, {15'd0, exp_w});
                end
            end
            if (timeout) to_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input int k, input logic l);
        addrR_in[8*m +: 8] = 8'(k / 8);
        addrC_in[8*m +: 8] = 8'(k % 8);
        wdata_in[m]        = 1'(k ^ (k >> 2));
        last[m]            = l;
    endtask

    // n beats from master m, beat k at (k/8, k%8); last on final beat if lastflag
    task automatic run_burst(input int m, input int n, input logic lastflag);
        for (int k = 0; k < n; k++) begin
            tick();
            set_m(m, k, lastflag && (k == n - 1));
            sb.push_back({8'(k / 8), 8'(k % 8), 1'(k ^ (k >> 2))});
            @(negedge clk);
            check("burst_gnt", {29'd0, gnt}, 32'(3'b001 << m));
        end
    endtask

    task automatic do_reset(input logic m);
        tick();
        rst = 1'b1; req = 3'b000; last = 3'b000; mode = m;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; req = 3'b000; last = 3'b000;
        addrR_in = '0; addrC_in = '0; wdata_in = '0;
        #2;
        check("rst_gnt", {29'd0, gnt}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_we", {31'd0, write_en}, 0);
        check("rst_timeout", {31'd0, timeout}, 0);
        check("rst_addr", {16'd0, wAddrR, wAddrC}, 0);

        // 1: fill burst of 64 ending at (7,7)
        tick();
        rst = 1'b0; req = 3'b010;
        @(negedge clk);
        check("t1_req_cycle_gnt", {29'd0, gnt}, 0);
        we_base = we_cnt; to_base = to_cnt;
        run_burst(1, 64, 1'b1);
        tick();
        req = 3'b000; last = 3'b000;
        @(negedge clk);
        check("t1_release_gnt", {29'd0, gnt}, 0);
        check("t1_beats", 32'(we_cnt - we_base), 64);
        check("t1_no_timeout", 32'(to_cnt - to_base), 0);

        // 2: fill and usr together from ptr=0
        do_reset(1'b0);
        req = 3'b110; set_m(2, 0, 1'b1);
        @(negedge clk);
        check("t2_idle_gnt", {29'd0, gnt}, 0);
        run_burst(1, 3, 1'b1);
        tick();
        req = 3'b100;
        addrR_in[23:16] = 8'd3; addrC_in[23:16] = 8'd5; wdata_in[2] = 1'b1; last[2] = 1'b1;
        @(negedge clk);
        check("t2_dead_cycle_gnt", {29'd0, gnt}, 0);
        check("t2_dead_cycle_we", {31'd0, write_en}, 0);
        tick();
        sb.push_back({8'd3, 8'd5, 1'b1});
        @(negedge clk);
        check("t2_usr_gnt", {29'd0, gnt}, 32'b100);
        tick();
        req = 3'b110; set_m(1, 0, 1'b1);
        @(negedge clk);
        check("t2_usr_release", {29'd0, gnt}, 0);
        tick();
        sb.push_back({8'd0, 8'd0, 1'b0});
        @(negedge clk);
        check("t2_ptr0_fill_wins", {29'd0, gnt}, 32'b010);
        tick();
        req = 3'b000;

        // 3: fill never signals last, forced release after 64 beats
        do_reset(1'b0);
        req = 3'b010;
        we_base = we_cnt; to_base = to_cnt;
        run_burst(1, 64, 1'b0);
        tick();
        req = 3'b000;
        @(negedge clk);
        check("t3_gnt", {29'd0, gnt}, 0);
        check("t3_timeout", {31'd0, timeout}, 1);
        tick();
        @(negedge clk);
        check("t3_timeout_drop", {31'd0, timeout}, 0);
        check("t3_beats", 32'(we_cnt - we_base), 64);
        check("t3_to_pulses", 32'(to_cnt - to_base), 1);

        // 4: mode flips during a fill burst
        do_reset(1'b0);
        req = 3'b010;
        to_base = to_cnt;
        run_burst(1, 10, 1'b0);
        tick();
        mode = 1'b1; req = 3'b011;
        addrR_in[7:0] = 8'd1; addrC_in[7:0] = 8'd2; wdata_in[0] = 1'b0; last[0] = 1'b1;
        @(negedge clk);
        check("t4_flip_we", {31'd0, write_en}, 0);
        check("t4_flip_gnt", {29'd0, gnt}, 32'b010);
        tick();
        @(negedge clk);
        check("t4_release_gnt", {29'd0, gnt}, 0);
        check("t4_no_timeout", {31'd0, timeout}, 0);
        tick();
        sb.push_back({8'd1, 8'd2, 1'b0});
        @(negedge clk);
        check("t4_gen_gnt", {29'd0, gnt}, 32'b001);
        tick();
        req = 3'b000;
        @(negedge clk);
        check("t4_to_pulses", 32'(to_cnt - to_base), 0);

        // 5: async reset mid gen burst, beat count restarts
        do_reset(1'b1);
        req = 3'b001;
        run_burst(0, 20, 1'b0);
        tick();
        set_m(0, 20, 1'b0);
        rst = 1'b1;
        #1;
        check("t5_async_gnt", {29'd0, gnt}, 0);
        check("t5_async_we", {31'd0, write_en}, 0);
        check("t5_async_busy", {31'd0, busy}, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_post_rst_gnt", {29'd0, gnt}, 0);
        we_base = we_cnt; to_base = to_cnt;
        run_burst(0, 64, 1'b0);
        tick();
        req = 3'b000;
        @(negedge clk);
        check("t5_timeout", {31'd0, timeout}, 1);
        check("t5_beats", 32'(we_cnt - we_base), 64);

        // 6: run mode masks fill and usr
        do_reset(1'b1);
        req = 3'b110;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("t6_gnt", {29'd0, gnt}, 0);
            check("t6_we", {31'd0, write_en}, 0);
        end
        req = 3'b000;

        tick();
        check("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
